mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port arbiter that shares one main-memory port among any number of cache-side requesters (I-cache, D-cache read, D-cache write, future prefetch/DMA). It supersedes the fixed three-port arbiter with a registered FSM, selectable fixed-priority or round-robin grant, per-port read/write, and a full four-phase handshake on both sides. It sits between the L1 caches and main memory.

## Interface
Parameters:
- NUM_PORTS, 4: number of requester ports (≥2)
- ADDR_W, `REG_SIZE: address width
- DATA_W, `WIDTH: data/line width
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (port 0 highest)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_PORTS  per-port request, level, held until ack
- we  in  NUM_PORTS  per-port 1 = write, 0 = read
- addr  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  packed write data
- ack  out  NUM_PORTS  per-port acknowledge, one-hot or zero
- rdata  out  DATA_W  read data for the acked port, valid while its ack high
- grant_id  out  $clog2(NUM_PORTS)  index of the port owning memory
- busy  out  1  high in every state except IDLE
- mem_enable  out  1  memory request
- mem_rw  out  1  1 = read, 0 = write (codebase convention)
- mem_addr  out  ADDR_W  latched address
- mem_data_in  out  DATA_W  latched write data
- mem_ack  in  1  memory acknowledge, four-phase
- mem_data_out  in  DATA_W  memory read data

## Operation
- All outputs registered; reset value 0 for every output, RR pointer = 0, state = IDLE.
- States: IDLE, BUSY, ACK, DRAIN.
- IDLE: if any req and mem_ack low, pick winner; latch grant_id, mem_addr, mem_data_in, mem_rw = ~we[w]; mem_enable<=1; -> BUSY. If mem_ack still high, stay IDLE.
- Fixed mode: lowest index wins. RR mode: first requesting index at or after pointer (wrapping NUM_PORTS-1 -> 0); pointer <= winner+1 mod NUM_PORTS at grant.
- BUSY: on mem_ack high: if read, rdata<=mem_data_out; if req[grant_id] still high, ack[grant_id]<=1, -> ACK; else (requester aborted) mem_enable<=0, -> DRAIN.
- ACK: hold ack, mem_enable until req[grant_id] low; then ack<=0, mem_enable<=0, -> DRAIN.
- DRAIN: wait mem_ack low -> IDLE. No new grant until memory handshake fully closed.
- rdata holds last read value until next read completes; writes never alter rdata.
- Requests from non-granted ports are ignored (not queued) until IDLE.

## Timing
- Grant latency: req sampled high in IDLE at edge n -> mem_enable high after edge n.
- mem_ack sampled at edge m -> ack/rdata valid after edge m.
- Requester drops req at edge k -> ack, mem_enable low after edge k.
- Minimum transaction (zero-wait memory): 4 cycles IDLE-to-IDLE; back-to-back grants separated by ≥1 IDLE cycle.
- Simultaneous requests resolve in one cycle by mode rule; a port dropping req while not granted has no effect.
- Reset assertion in any state: all outputs 0 asynchronously, state IDLE, pointer 0; memory-side in-flight transaction abandoned.
- NUM_PORTS not power of two: pointer wraps at NUM_PORTS-1, never holds an invalid index.

## Structure
- Widths REG_SIZE, WIDTH remain in shared define.v; state encoding defined locally as localparams.
- One sub-module: rr_pick (combinational, NUM_PORTS param): inputs req vector, pointer, mode; outputs winner index and valid. FSM and datapath latches in mem_arbiter_rr.

## Test plan
- Single read, port 2, addr 0x40, memory returns 0xDEADBEEF after 3 wait cycles -> ack[2] one cycle after mem_ack, rdata=0xDEADBEEF, mem_rw=1.
- RR_MODE=1, all 4 ports hold req continuously -> grants 0,1,2,3,0 in order, each completed transaction advances grant_id.
- RR_MODE=0, ports 1 and 3 request together -> port 1 granted; port 3 served only after port 1 releases.
- Port 0 write 0x1234 to 0x10, then drops req before mem_ack -> no ack[0], mem_enable falls after mem_ack, FSM passes DRAIN to IDLE.
- Reset pulled low while in ACK -> ack, mem_enable, busy 0 immediately; after release, next request granted starting from pointer 0.
- NUM_PORTS=3, RR: ports 2 and 0 requesting, pointer at 2 -> grant 2 then wrap to 0.

Source files
------------

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared widths, FSM state type and pointer helper for the N-port memory arbiter.
package mem_arbiter_rr_pkg;

  // Codebase-wide register and line widths.
  localparam int unsigned REG_SIZE = 32;
  localparam int unsigned WIDTH    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAck,
    StDrain
  } arb_state_e;

  // Index after idx, wrapping to 0 at n so the pointer never holds an invalid port.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Requester-side and memory-side bus of the arbiter, grouped in one interface.
interface mem_arbiter_rr_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = mem_arbiter_rr_pkg::REG_SIZE,
  parameter int unsigned DATA_W    = mem_arbiter_rr_pkg::WIDTH
);
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Requester side
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        ack;
  logic [DATA_W-1:0]           rdata;
  logic [IDX_W-1:0]            grant_id;
  logic                        busy;

  // Memory side; mem_rw is 1 for read
  logic                        mem_enable;
  logic                        mem_rw;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_data_in;
  logic                        mem_ack;
  logic [DATA_W-1:0]           mem_data_out;

  // Arbiter view: masters the memory port and answers requesters.
  modport master (
    input  req, we, addr, wdata, mem_ack, mem_data_out,
    output ack, rdata, grant_id, busy, mem_enable, mem_rw, mem_addr, mem_data_in
  );

  // Environment view: requesters plus the memory model.
  modport slave (
    output req, we, addr, wdata, mem_ack, mem_data_out,
    input  ack, rdata, grant_id, busy, mem_enable, mem_rw, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin from a pointer.
module mem_arbiter_rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 rr_mode_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic                 valid_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      // ptr + k stays below 2*NUM_PORTS, so one conditional subtract wraps it.
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
        sum = sum - (IDX_W+1)'(NUM_PORTS);
      end
      idx = rr_mode_i ? sum[IDX_W-1:0] : IDX_W'(k);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter sharing one four-phase memory port among cache requesters.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = REG_SIZE,
  parameter int unsigned DATA_W    = WIDTH,
  parameter bit          RR_MODE   = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mem_arbiter_rr_if.master bus
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_data_in_q, mem_data_in_d;

  logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];
  logic [IDX_W-1:0]     pick_winner;
  logic                 pick_valid;
  logic                 grant_req;

  // Unpack the flat per-port address and write-data buses.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      addr_arr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = bus.wdata[i*DATA_W +: DATA_W];
    end
  end

  assign grant_req = bus.req[grant_id_q];

  mem_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .rr_mode_i (RR_MODE),
    .winner_o  (pick_winner),
    .valid_o   (pick_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a grant only opens once memory has dropped its previous ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid && !bus.mem_ack) state_d = StBusy;
      StBusy:  if (bus.mem_ack) state_d = grant_req ? StAck : StDrain;
      StAck:   if (!grant_req) state_d = StDrain;
      StDrain: if (!bus.mem_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; everything holds unless the current state updates it.
  always_comb begin
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    ack_d         = ack_q;
    rdata_d       = rdata_q;
    mem_enable_d  = mem_enable_q;
    mem_rw_d      = mem_rw_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !bus.mem_ack) begin
          grant_id_d    = pick_winner;
          mem_addr_d    = addr_arr[pick_winner];
          mem_data_in_d = wdata_arr[pick_winner];
          mem_rw_d      = ~bus.we[pick_winner];
          mem_enable_d  = 1'b1;
          if (RR_MODE) begin
            ptr_d = IDX_W'(wrap_inc(32'(pick_winner), NUM_PORTS));
          end
        end
      end
      StBusy: begin
        if (bus.mem_ack) begin
          if (mem_rw_q) begin
            rdata_d = bus.mem_data_out;
          end
          if (grant_req) begin
            ack_d             = '0;
            ack_d[grant_id_q] = 1'b1;
          end else begin
            // Requester gave up: close the memory handshake without acking anyone.
            mem_enable_d = 1'b0;
          end
        end
      end
      StAck: begin
        if (!grant_req) begin
          ack_d        = '0;
          mem_enable_d = 1'b0;
        end
      end
      StDrain: begin
      end
      default: begin
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // Registered outputs and latched transaction fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q         <= '0;
      grant_id_q    <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      mem_enable_q  <= mem_enable_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: 4-port round-robin, 4-port fixed-priority and 3-port round-robin arbiters.
module tb_mem_arbiter_rr;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) b4 ();
  mem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bf ();
  mem_arbiter_rr_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) b3 ();

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1)) u_rr4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b0)) u_fx4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bf)
  );

  mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1)) u_rr3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b4.req = '0; b4.we = '0; b4.addr = '0; b4.wdata = '0; b4.mem_ack = 1'b0; b4.mem_data_out = '0;
    bf.req = '0; bf.we = '0; bf.addr = '0; bf.wdata = '0; bf.mem_ack = 1'b0; bf.mem_data_out = '0;
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0; b3.mem_ack = 1'b0; b3.mem_data_out = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One zero-wait read on the 4-port RR arbiter, starting from IDLE.
  task automatic rr4_txn(input int p, input logic [31:0] d, input bit rearm);
    logic [3:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    tick();
    checks++;
    if (b4.grant_id !== 2'(p) || b4.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL rr4_grant: grant_id=%0d mem_enable=%b, want %0d/1", b4.grant_id,
               b4.mem_enable, p);
    end
    b4.mem_ack = 1'b1;
    b4.mem_data_out = d;
    tick();
    checks++;
    if (b4.ack !== oh || b4.rdata !== d) begin
      errors++;
      $display("FAIL rr4_ack: ack=%b rdata=%h, want %b/%h", b4.ack, b4.rdata, oh, d);
    end
    b4.req[p] = 1'b0;
    tick();
    checks++;
    if (b4.ack !== 4'b0 || b4.mem_enable !== 1'b0 || b4.busy !== 1'b1) begin
      errors++;
      $display("FAIL rr4_release: ack=%b mem_enable=%b busy=%b, want 0000/0/1", b4.ack,
               b4.mem_enable, b4.busy);
    end
    b4.mem_ack = 1'b0;
    b4.req[p] = rearm;
    tick();
    checks++;
    if (b4.busy !== 1'b0) begin
      errors++;
      $display("FAIL rr4_idle: busy=%b, want 0", b4.busy);
    end
  endtask

  // One zero-wait read on the fixed-priority arbiter.
  task automatic bf_txn(input int p, input bit rearm);
    logic [3:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    tick();
    checks++;
    if (bf.grant_id !== 2'(p) || bf.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL fx_grant: grant_id=%0d mem_enable=%b, want %0d/1", bf.grant_id,
               bf.mem_enable, p);
    end
    bf.mem_ack = 1'b1;
    tick();
    checks++;
    if (bf.ack !== oh) begin
      errors++;
      $display("FAIL fx_ack: ack=%b, want %b", bf.ack, oh);
    end
    bf.req[p] = 1'b0;
    tick();
    checks++;
    if (bf.ack !== 4'b0 || bf.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL fx_release: ack=%b mem_enable=%b, want 0000/0", bf.ack, bf.mem_enable);
    end
    bf.mem_ack = 1'b0;
    bf.req[p] = rearm;
    tick();
    checks++;
    if (bf.busy !== 1'b0) begin
      errors++;
      $display("FAIL fx_idle: busy=%b, want 0", bf.busy);
    end
  endtask

  // One zero-wait read on the 3-port RR arbiter; the granted port drops its request.
  task automatic b3_txn(input int p);
    logic [2:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    tick();
    checks++;
    if (b3.grant_id !== 2'(p) || b3.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL rr3_grant: grant_id=%0d mem_enable=%b, want %0d/1", b3.grant_id,
               b3.mem_enable, p);
    end
    b3.mem_ack = 1'b1;
    tick();
    checks++;
    if (b3.ack !== oh) begin
      errors++;
      $display("FAIL rr3_ack: ack=%b, want %b", b3.ack, oh);
    end
    b3.req[p] = 1'b0;
    tick();
    b3.mem_ack = 1'b0;
    tick();
    checks++;
    if (b3.busy !== 1'b0 || b3.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL rr3_idle: busy=%b mem_enable=%b, want 0/0", b3.busy, b3.mem_enable);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (b4.busy !== 1'b0 || b4.mem_enable !== 1'b0 || b4.mem_rw !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b mem_enable=%b mem_rw=%b, want 0/0/0", b4.busy,
               b4.mem_enable, b4.mem_rw);
    end
    checks++;
    if (b4.ack !== 4'b0 || b4.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_ack: ack=%b grant_id=%0d, want 0000/0", b4.ack, b4.grant_id);
    end
    checks++;
    if (b4.rdata !== 32'h0 || b4.mem_addr !== 32'h0 || b4.mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_data_in=%h, want 0", b4.rdata,
               b4.mem_addr, b4.mem_data_in);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    b4.req = 4'b0100;
    b4.addr[2*32 +: 32] = 32'h40;
    tick();
    checks++;
    if (b4.grant_id !== 2'd2 || b4.mem_enable !== 1'b1 || b4.mem_rw !== 1'b1 ||
        b4.mem_addr !== 32'h40 || b4.busy !== 1'b1) begin
      errors++;
      $display("FAIL read_grant: grant_id=%0d en=%b rw=%b addr=%h busy=%b, want 2/1/1/40/1",
               b4.grant_id, b4.mem_enable, b4.mem_rw, b4.mem_addr, b4.busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b4.ack !== 4'b0 || b4.mem_enable !== 1'b1) begin
        errors++;
        $display("FAIL read_wait%0d: ack=%b mem_enable=%b, want 0000/1", i, b4.ack,
                 b4.mem_enable);
      end
    end
    b4.mem_ack = 1'b1;
    b4.mem_data_out = 32'hDEADBEEF;
    tick();
    checks++;
    if (b4.ack !== 4'b0100 || b4.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_ack: ack=%b rdata=%h, want 0100/deadbeef", b4.ack, b4.rdata);
    end
    b4.req = 4'b0000;
    tick();
    checks++;
    if (b4.ack !== 4'b0 || b4.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL read_release: ack=%b mem_enable=%b, want 0000/0", b4.ack, b4.mem_enable);
    end
    b4.mem_ack = 1'b0;
    b4.mem_data_out = 32'h0;
    tick();
    checks++;
    if (b4.busy !== 1'b0 || b4.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_done: busy=%b rdata=%h, want 0/deadbeef", b4.busy, b4.rdata);
    end
  endtask

  task automatic test_write_abort();
    // Pointer sits at 3 after the port-2 read; port 0 is the only requester.
    b4.req = 4'b0001;
    b4.we = 4'b0001;
    b4.addr[0 +: 32] = 32'h10;
    b4.wdata[0 +: 32] = 32'h1234;
    tick();
    checks++;
    if (b4.grant_id !== 2'd0 || b4.mem_rw !== 1'b0 || b4.mem_addr !== 32'h10 ||
        b4.mem_data_in !== 32'h1234 || b4.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: grant_id=%0d rw=%b addr=%h wdata=%h en=%b, want 0/0/10/1234/1",
               b4.grant_id, b4.mem_rw, b4.mem_addr, b4.mem_data_in, b4.mem_enable);
    end
    b4.req = 4'b0000;
    tick();
    checks++;
    if (b4.mem_enable !== 1'b1 || b4.ack !== 4'b0 || b4.busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_abort_hold: en=%b ack=%b busy=%b, want 1/0000/1", b4.mem_enable,
               b4.ack, b4.busy);
    end
    b4.mem_ack = 1'b1;
    b4.mem_data_out = 32'hBAD0BAD0;
    tick();
    checks++;
    if (b4.mem_enable !== 1'b0 || b4.ack !== 4'b0 || b4.busy !== 1'b1 ||
        b4.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_abort_drain: en=%b ack=%b busy=%b rdata=%h, want 0/0000/1/deadbeef",
               b4.mem_enable, b4.ack, b4.busy, b4.rdata);
    end
    // A new request while memory still acks must not be granted.
    b4.we = 4'b0000;
    b4.req = 4'b0010;
    tick();
    checks++;
    if (b4.busy !== 1'b1 || b4.mem_enable !== 1'b0 || b4.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL wr_drain_hold: busy=%b en=%b grant_id=%0d, want 1/0/0", b4.busy,
               b4.mem_enable, b4.grant_id);
    end
    b4.mem_ack = 1'b0;
    tick();
    checks++;
    if (b4.busy !== 1'b0 || b4.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: busy=%b en=%b, want 0/0", b4.busy, b4.mem_enable);
    end
    b4.req = 4'b0000;
  endtask

  task automatic test_rr_rotation();
    do_reset();
    // All ports request, but memory still holds ack from before: no grant yet.
    b4.req = 4'b1111;
    b4.mem_ack = 1'b1;
    tick();
    checks++;
    if (b4.busy !== 1'b0 || b4.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL rr_ack_block: busy=%b en=%b, want 0/0", b4.busy, b4.mem_enable);
    end
    b4.mem_ack = 1'b0;
    rr4_txn(0, 32'h100, 1'b1);
    rr4_txn(1, 32'h101, 1'b1);
    rr4_txn(2, 32'h102, 1'b1);
    rr4_txn(3, 32'h103, 1'b1);
    rr4_txn(0, 32'h104, 1'b0);
    b4.req = 4'b0000;
  endtask

  task automatic test_fixed_priority();
    bf.req = 4'b1010;
    // Port 1 keeps winning while it re-requests; port 3 waits.
    bf_txn(1, 1'b1);
    bf_txn(1, 1'b0);
    bf_txn(3, 1'b0);
    bf.req = 4'b0000;
  endtask

  task automatic test_reset_in_ack();
    // Pointer is 1 here, so port 2 wins.
    b4.req = 4'b0100;
    tick();
    checks++;
    if (b4.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL rst_ack_grant: grant_id=%0d, want 2", b4.grant_id);
    end
    b4.mem_ack = 1'b1;
    tick();
    checks++;
    if (b4.ack !== 4'b0100) begin
      errors++;
      $display("FAIL rst_ack_pre: ack=%b, want 0100", b4.ack);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (b4.ack !== 4'b0 || b4.mem_enable !== 1'b0 || b4.busy !== 1'b0 ||
        b4.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: ack=%b en=%b busy=%b grant_id=%0d, want 0000/0/0/0", b4.ack,
               b4.mem_enable, b4.busy, b4.grant_id);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    // Pointer back at 0: port 1 wins over port 3.
    b4.req = 4'b1010;
    tick();
    checks++;
    if (b4.grant_id !== 2'd1 || b4.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL rst_ptr: grant_id=%0d en=%b, want 1/1", b4.grant_id, b4.mem_enable);
    end
    b4.mem_ack = 1'b1;
    tick();
    b4.req = 4'b0000;
    tick();
    b4.mem_ack = 1'b0;
    tick();
    checks++;
    if (b4.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_finish: busy=%b, want 0", b4.busy);
    end
  endtask

  task automatic test_three_port_wrap();
    // Serve port 1 so the pointer lands on 2.
    b3.req = 3'b010;
    b3_txn(1);
    b3.req = 3'b101;
    b3_txn(2);
    b3_txn(0);
    // Pointer now 1: with 0 and 2 requesting, 2 comes first.
    b3.req = 3'b101;
    b3_txn(2);
    b3.req = 3'b000;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_abort();
    test_rr_rotation();
    test_fixed_priority();
    test_reset_in_ack();
    test_three_port_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
